// File: rtl/snn_cmd_master.sv
// Host-facing command sequencer for an SNN core: buffers host entries in a small FIFO,
// issues them one per cycle on a registered bus, and closes each batch with a CLEAR and settle.
module snn_cmd_master #(
  parameter int unsigned           ADDR_WIDTH    = 8,
  parameter int unsigned           CMD_WIDTH     = 8,
  parameter int unsigned           FLOAT_WIDTH   = 16,
  parameter int unsigned           FIFO_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR     = ADDR_WIDTH'(255),
  parameter logic [CMD_WIDTH-1:0]  IDLE_CMD      = CMD_WIDTH'(255),
  parameter logic [CMD_WIDTH-1:0]  CLEAR_CMD     = '0,
  parameter int unsigned           SETTLE_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ADDR_WIDTH-1:0]  s_addr,
  input  logic [CMD_WIDTH-1:0]   s_cmd,
  input  logic [FLOAT_WIDTH-1:0] s_arg,
  input  logic                   s_last,
  input  logic                   abort,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [CMD_WIDTH-1:0]   cmd,
  output logic [FLOAT_WIDTH-1:0] cmd_arg,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef struct packed {
    logic                   last;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [CMD_WIDTH-1:0]   cmd;
    logic [FLOAT_WIDTH-1:0] arg;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CLEAR, SETTLE} state_t;

  entry_t                 mem_q [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
  logic [FLOAT_WIDTH-1:0] arg_q, arg_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic   fifo_empty, fifo_full, accept, push, pop;
  entry_t head, entry_in;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign s_ready    = !fifo_full && !abort;
  assign accept     = s_valid && s_ready;
  assign push       = accept && (s_cmd != IDLE_CMD);
  assign entry_in   = '{last: s_last, addr: s_addr, cmd: s_cmd, arg: s_arg};
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q | (accept && (s_cmd == IDLE_CMD));
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = IDLE_ADDR;
    cmd_d   = IDLE_CMD;
    arg_d   = '0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // last_q refers to the entry currently on the bus.
        if (last_q) begin
          cmd_d   = CLEAR_CMD;
          state_d = CLEAR;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      CLEAR: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      addr_d = head.addr;
      cmd_d  = head.cmd;
      arg_d  = head.arg;
      last_d = head.last;
    end
    // Flush wins over everything, including a done pulse about to fire.
    if (abort) begin
      state_d = IDLE;
      pop     = 1'b0;
      addr_d  = IDLE_ADDR;
      cmd_d   = IDLE_CMD;
      arg_d   = '0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      addr_q   <= IDLE_ADDR;
      cmd_q    <= IDLE_CMD;
      arg_q    <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      arg_q    <= arg_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign addr    = addr_q;
  assign cmd     = cmd_q;
  assign cmd_arg = arg_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_snn_cmd_master.sv
// Scoreboard bench for snn_cmd_master: accepted entries feed an ordered queue; a negedge
// monitor checks issue order, batch CLEAR, settle length, done pulse and the sticky error.
module tb_snn_cmd_master;

  localparam logic [7:0] IA     = 8'hFF;
  localparam logic [7:0] IC     = 8'hFF;
  localparam logic [7:0] CC     = 8'h00;
  localparam int         SETTLE = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0, abort = 1'b0;
  logic [7:0]  s_addr = '0, s_cmd = '0;
  logic [15:0] s_arg = '0;
  logic [7:0]  addr, cmd;
  logic [15:0] cmd_arg;
  logic        busy, done, err;

  snn_cmd_master dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_cmd(s_cmd), .s_arg(s_arg), .s_last(s_last),
    .abort(abort), .addr(addr), .cmd(cmd), .cmd_arg(cmd_arg),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  c;
    logic [15:0] g;
    logic        l;
  } ent_t;

  ent_t q[$];
  int   ent_cycles[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, acc_cyc = 0, settle_cnt = -1, done_count = 0;
  bit   clear_next = 0, err_exp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor + reference model: checks outputs of the previous edge, then records the
  // handshake that the coming edge will complete.
  always @(negedge clk) begin
    logic bus_idle;
    cyc++;
    bus_idle = (addr == IA) && (cmd == IC) && (cmd_arg == 16'h0);
    if (rst) begin
      q.delete();
      settle_cnt = -1;
      clear_next = 0;
      err_exp    = 0;
      chk("reset_outputs", {addr, cmd, cmd_arg, done, err}, {IA, IC, 16'h0, 1'b0, 1'b0});
    end else begin
      chk("err_flag", err, err_exp);
      if (settle_cnt >= 0) begin
        if (settle_cnt < SETTLE) begin
          chk("settle_idle", {addr, cmd, cmd_arg, done}, {IA, IC, 16'h0, 1'b0});
          settle_cnt++;
        end else begin
          chk("done_pulse", {addr, cmd, cmd_arg, done}, {IA, IC, 16'h0, 1'b1});
          settle_cnt = -1;
          done_count++;
        end
      end else if (clear_next) begin
        chk("clear_cmd", {addr, cmd, cmd_arg, done}, {IA, CC, 16'h0, 1'b0});
        clear_next = 0;
        settle_cnt = 0;
      end else if (done) begin
        chk("unexpected_done", done, 1'b0);
      end else if (!bus_idle) begin
        if (q.size() == 0) begin
          chk("unexpected_issue", {addr, cmd, cmd_arg}, {IA, IC, 16'h0});
        end else begin
          ent_t e;
          e = q.pop_front();
          chk("issue", {addr, cmd, cmd_arg}, {e.a, e.c, e.g});
          ent_cycles.push_back(cyc);
          if (e.l) clear_next = 1;
        end
      end
      if (abort) begin
        q.delete();
        settle_cnt = -1;
        clear_next = 0;
      end else if (s_valid && s_ready) begin
        acc_cyc = cyc;
        if (s_cmd == IC) err_exp = 1;
        else q.push_back('{a: s_addr, c: s_cmd, g: s_arg, l: s_last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] c, input logic [15:0] g, input logic l);
    bit got = 0;
    s_valid = 1'b1; s_addr = a; s_cmd = c; s_arg = g; s_last = l;
    for (int t = 0; t < 50 && !got; t++) begin
      #1;
      got = s_ready;
      tick();
    end
    s_valid = 1'b0;
    if (!got) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_settle();
    int t = 0;
    while (t < 50 && settle_cnt < 0) begin tick(); t++; end
    chk("settle_wait_timeout", t < 50, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while (t < 300 && !(q.size() == 0 && settle_cnt < 0 && !clear_next)) begin tick(); t++; end
    chk("drain_timeout", t < 300, 1'b1);
  endtask

  initial begin
    int a0, d0, busy_after;
    #1 rst = 1'b1;
    #1 chk("reset_bus", {addr, cmd, cmd_arg, done, err, busy}, {IA, IC, 16'h0, 1'b0, 1'b0, 1'b0});
    #10 rst = 1'b0;
    #1 chk("ready_after_reset", s_ready, 1'b1);
    tick();

    // single entry into an idle block: latency, clear, settle, done
    ent_cycles.delete(); d0 = done_count;
    send(8'd3, 8'd1, 16'h0040, 1'b1);
    a0 = acc_cyc;
    drain();
    chk("single_count", ent_cycles.size(), 1);
    if (ent_cycles.size() > 0) chk("single_latency", ent_cycles[0], a0 + 2);
    chk("single_done", done_count, d0 + 1);

    // FIFO fill while settling, then back-to-back drain
    send(8'h10, 8'd2, 16'h1111, 1'b1);
    wait_settle();
    ent_cycles.delete();
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 8'd3 + 8'(i), 16'hA000 + 16'(i), 1'b0);
    chk("ready_when_full", s_ready, 1'b0);
    send(8'h24, 8'd7, 16'h8004, 1'b1);
    a0 = acc_cyc;
    drain();
    chk("fill_count", ent_cycles.size(), 5);
    if (ent_cycles.size() == 5) begin
      chk("fifth_accept_at_first_pop", a0, ent_cycles[0]);
      for (int i = 1; i < 5; i++) chk("back_to_back", ent_cycles[i], ent_cycles[0] + i);
    end

    // IDLE_CMD entry is rejected and err sticks
    chk("err_before", err, 1'b0);
    send(8'd5, IC, 16'h1234, 1'b1);
    repeat (3) tick();
    chk("err_set", err, 1'b1);

    // two batches: 2 entries (second carries CLEAR_CMD as data), then 1 entry
    ent_cycles.delete(); d0 = done_count;
    send(8'h30, 8'd1, 16'hFFFF, 1'b0);
    send(8'h31, CC, 16'h8000, 1'b1);
    send(8'h32, 8'd4, 16'h7FFF, 1'b1);
    drain();
    chk("batches_done", done_count, d0 + 2);
    chk("batches_count", ent_cycles.size(), 3);
    if (ent_cycles.size() == 3) begin
      chk("batch1_gap", ent_cycles[1] - ent_cycles[0], 1);
      chk("batch2_gap", ent_cycles[2] - ent_cycles[1], SETTLE + 3);
    end

    // abort during settle with two entries queued; simultaneous entry is dropped
    send(8'h09, 8'd1, 16'h0001, 1'b1);
    wait_settle();
    send(8'h40, 8'd1, 16'h0002, 1'b0);
    send(8'h41, 8'd1, 16'h0003, 1'b1);
    d0 = done_count;
    abort = 1'b1; s_valid = 1'b1; s_addr = 8'h42; s_cmd = 8'd1; s_arg = 16'h0004; s_last = 1'b1;
    #1 chk("ready_during_abort", s_ready, 1'b0);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    busy_after = busy;
    chk("busy_after_abort", busy_after, 1'b0);
    repeat (12) tick();
    chk("no_done_after_abort", done_count, d0);
    chk("err_still_sticky", err, 1'b1);

    // reset mid-batch with the second of three entries on the bus
    send(8'h50, 8'd1, 16'h0010, 1'b0);
    send(8'h51, 8'd2, 16'h0020, 1'b0);
    send(8'h52, 8'd3, 16'h0030, 1'b1);
    chk("mid_batch_bus", {addr, cmd, cmd_arg}, {8'h51, 8'd2, 16'h0020});
    #1 rst = 1'b1;
    #1 chk("async_reset", {addr, cmd, cmd_arg, done, err, busy}, {IA, IC, 16'h0, 1'b0, 1'b0, 1'b0});
    tick(); tick();
    #1 rst = 1'b0;
    #1 chk("ready_after_midreset", s_ready, 1'b1);
    d0 = done_count;
    repeat (12) tick();
    chk("no_clear_after_reset", done_count, d0);

    // randomized traffic including rejects and aborts
    for (int n = 0; n < 400; n++) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_addr  = 8'($urandom);
      s_cmd   = ($urandom_range(0, 15) == 0) ? IC : 8'($urandom_range(0, 254));
      s_arg   = 16'($urandom);
      s_last  = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 49) == 0);
      tick();
    end
    s_valid = 1'b0; abort = 1'b0;
    send(8'h01, 8'h01, 16'h0001, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_cmd_master.md
SNN_CMD_MASTER -- requirements
Module: snn_cmd_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the neuron address bus width.
REQ-002 Parameter CMD_WIDTH, default 8, sets the command bus width.
REQ-003 Parameter FLOAT_WIDTH, default 16, sets the command argument width (signed fixed-point weight).
REQ-004 Parameter FIFO_DEPTH, default 4, sets the entry buffer depth, power of 2 and at least 2.
REQ-005 Parameter IDLE_ADDR, default 255, is the address driven when no neuron is targeted.
REQ-006 Parameter IDLE_CMD, default 255, is the no-op command value; it is never 0.
REQ-007 Parameter CLEAR_CMD, default 0, is the broadcast neuron state-clear command.
REQ-008 Parameter SETTLE_CYCLES, default 5, sets the idle cycles held after a clear.
REQ-009 Reset rst is asynchronous and active-high; clock clk.
REQ-010 clk, input, 1: rising-edge clock.
REQ-011 rst, input, 1: asynchronous active-high reset.
REQ-012 s_valid, input, 1: a host entry is offered.
REQ-013 s_ready, output, 1: the block accepts an entry; high iff FIFO not full and abort low.
REQ-014 s_addr / s_cmd / s_arg, input, ADDR_WIDTH / CMD_WIDTH / FLOAT_WIDTH: the entry fields.
REQ-015 s_last, input, 1: the entry closes a batch.
REQ-016 abort, input, 1: synchronous flush request.
REQ-017 addr / cmd / cmd_arg, output, ADDR_WIDTH / CMD_WIDTH / FLOAT_WIDTH: registered neuron configuration bus.
REQ-018 busy, output, 1: high whenever the state is not IDLE or the FIFO is non-empty.
REQ-019 done, output, 1: one-cycle pulse when settling completes.
REQ-020 err, output, 1: sticky flag set when an entry is rejected.

Function
REQ-021 An entry is accepted on a rising edge where s_valid and s_ready are both 1.
REQ-022 An accepted entry with s_cmd == IDLE_CMD is discarded, not stored, and sets err.
REQ-023 The FIFO is first-in first-out; push and pop on the same edge leave the count unchanged.
REQ-024 The FSM has four states: IDLE, ISSUE, CLEAR and SETTLE.
REQ-025 In IDLE, CLEAR-exit and SETTLE, every cycle with no issued entry drives addr=IDLE_ADDR, cmd=IDLE_CMD, cmd_arg=0.
REQ-026 In IDLE with the FIFO non-empty, the block pops the head onto the bus at that edge and moves to ISSUE.
REQ-027 Latency: an entry accepted at edge k into an empty FIFO with the FSM in IDLE appears on the bus after edge k+1.
REQ-028 Each issued entry is driven on the bus for exactly one cycle.
REQ-029 In ISSUE with the FIFO non-empty and the previous entry not last, the block pops one entry per cycle back-to-back.
REQ-030 In ISSUE with the FIFO empty and the previous entry not last, the bus is idle and the FSM stays in ISSUE.
REQ-031 After the cycle carrying an s_last entry, the FSM enters CLEAR.
REQ-032 CLEAR lasts one cycle and drives addr=IDLE_ADDR, cmd=CLEAR_CMD, cmd_arg=0.
REQ-033 SETTLE holds the bus idle for exactly SETTLE_CYCLES cycles, then pulses done for one cycle and returns to IDLE.
REQ-034 The FIFO keeps accepting entries during CLEAR and SETTLE; it does not pop until IDLE.
REQ-035 abort clears the FIFO, returns the FSM to IDLE and drives the bus idle after the same edge.
REQ-036 A pending done pulse is suppressed when abort is asserted.
REQ-037 abort takes priority over a simultaneous s_valid; that entry is not stored.
REQ-038 cmd_arg passes s_arg bit-exact, with no sign or width conversion.
REQ-039 An entry with cmd == CLEAR_CMD is issued like any other entry.

Reset
REQ-040 rst asynchronously empties the FIFO, sets the FSM to IDLE, addr=IDLE_ADDR, cmd=IDLE_CMD, cmd_arg=0, done=0 and err=0.
REQ-041 Entries that were mid-issue when rst asserts are lost; after rst deasserts, s_ready is 1 on the first edge.

Verification
REQ-042 Single entry (addr=3, cmd=1, arg=0x0040, last=1) into an idle block -> after edge k+1 the bus shows 3/1/0x0040; the next cycle shows IDLE_ADDR/0/0; then 5 idle cycles; then done=1 for one cycle.
REQ-043 Push 5 entries back-to-back with the host stalled on drain -> s_ready drops after 4 entries; the 5th is accepted once the first pop occurs; all 5 issue in order on consecutive cycles.
REQ-044 Entry with cmd=255 -> it is never seen on the bus, err=1 and stays 1 until rst.
REQ-045 abort during SETTLE with 2 entries queued -> FIFO empties, no done pulse, the bus stays idle, and busy=0 on the next cycle.
REQ-046 rst asserted mid-batch (second of 3 entries on the bus) -> outputs return to idle values immediately without waiting for clk, and no CLEAR is issued.
REQ-047 Two batches queued (lengths 2 and 1) -> sequence: 2 entries, CLEAR, 5 idle, done, then 1 entry, CLEAR, 5 idle, done.
